// File: rtl/seed_loader.sv
`default_nettype none
// ============================================================================
// Module      : seed_loader
// Description : Streams an initial Game-of-Life generation into the
//               current-state row store one row per valid/ready handshake,
//               then checks a trailing XOR checksum word. A match releases
//               the generation controller through run_en; a mismatch keeps
//               the array frozen and raises a sticky err.
// Revision    : 1.0 - initial release
// ============================================================================
module seed_loader #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
) (
  input  logic               ph1,
  input  logic               reset,
  input  logic               load_start,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               wr_en,
  output logic [REGBITS-1:0] wr_addr,
  output logic [WIDTH-1:0]   wr_data,
  output logic               run_en,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  // Address of the final row; reaching it means the next word is the checksum.
  localparam logic [REGBITS-1:0] c_LAST_ROW = {REGBITS{1'b1}};

  logic [2:0]         r_state;
  logic [REGBITS-1:0] r_cnt;
  logic [WIDTH-1:0]   r_acc;
  logic               r_wr_en;
  logic [REGBITS-1:0] r_wr_addr;
  logic [WIDTH-1:0]   r_wr_data;
  logic               r_done;
  logic               r_err;

  logic               w_busy;
  logic               w_ready;
  logic               w_accept;

  // Handshake decode; a restart request blocks any word offered alongside it.
  always_comb begin
    w_busy   = (r_state == S_LOAD) || (r_state == S_CHECK);
    w_ready  = w_busy && !load_start;
    w_accept = w_ready && in_valid;
  end

  // Load sequencing: row counter, checksum accumulator and state transitions.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (load_start) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (w_accept) begin
      case (r_state)
        S_LOAD: begin
          r_acc <= r_acc ^ in_data;
          if (r_cnt == c_LAST_ROW) begin
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          r_state <= (in_data == r_acc) ? S_RUN : S_ERR;
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  // Row-store write port: one-cycle strobe per accepted row, address/data held.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_accept && (r_state == S_LOAD)) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_cnt;
        r_wr_data <= in_data;
      end
    end
  end

  // Verification result flags: done pulses once on a match, err is sticky until restart.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load_start) begin
        r_err <= 1'b0;
      end else if (w_accept && (r_state == S_CHECK)) begin
        if (in_data == r_acc) begin
          r_done <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // run_en decodes straight from state so it drops the moment RUN is left.
  always_comb begin
    in_ready = w_ready;
    busy     = w_busy;
    run_en   = (r_state == S_RUN);
    wr_en    = r_wr_en;
    wr_addr  = r_wr_addr;
    wr_data  = r_wr_data;
    done     = r_done;
    err      = r_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_seed_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_seed_loader
// Description : Randomized self-checking bench for seed_loader. A queue-based
//               model of the load protocol predicts every output each cycle;
//               directed scenarios add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seed_loader;

  localparam int WIDTH   = 8;
  localparam int REGBITS = 3;
  localparam int ROWS    = 1 << REGBITS;

  logic               ph1;
  logic               reset;
  logic               load_start;
  logic               in_valid;
  logic [WIDTH-1:0]   in_data;
  logic               in_ready;
  logic               wr_en;
  logic [REGBITS-1:0] wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic               run_en;
  logic               busy;
  logic               done;
  logic               err;

  int total = 0;
  int bad   = 0;

  seed_loader #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
    .ph1        (ph1),
    .reset      (reset),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .run_en     (run_en),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  // ---------------------------------------------------------------- model
  // A load is a list of words received so far; the first ROWS are rows, the
  // next one is the checksum compared against the XOR of the list.
  logic [WIDTH-1:0]   m_words[$];
  bit                 m_loading;
  bit                 m_running;
  bit                 e_wr_en;
  logic [REGBITS-1:0] e_wr_addr;
  logic [WIDTH-1:0]   e_wr_data;
  bit                 e_done;
  bit                 e_err;

  function automatic logic [WIDTH-1:0] xor_of(input logic [WIDTH-1:0] q[$]);
    logic [WIDTH-1:0] x = '0;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  always @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      m_words.delete();
      m_loading = 0; m_running = 0;
      e_wr_en = 0; e_wr_addr = '0; e_wr_data = '0; e_done = 0; e_err = 0;
    end else begin
      e_wr_en = 0;
      e_done  = 0;
      if (load_start) begin
        m_words.delete();
        m_loading = 1; m_running = 0; e_err = 0;
      end else if (m_loading && in_valid) begin
        if (m_words.size() < ROWS) begin
          e_wr_en   = 1;
          e_wr_addr = REGBITS'(m_words.size());
          e_wr_data = in_data;
          m_words.push_back(in_data);
        end else begin
          m_loading = 0;
          if (in_data == xor_of(m_words)) begin
            m_running = 1; e_done = 1;
          end else begin
            e_err = 1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: every cycle, all outputs against the model.
  always @(negedge ph1) begin
    check("in_ready", in_ready, m_loading && !load_start);
    check("busy",     busy,     m_loading);
    check("run_en",   run_en,   m_running);
    check("wr_en",    wr_en,    e_wr_en);
    check("wr_addr",  wr_addr,  e_wr_addr);
    check("wr_data",  wr_data,  e_wr_data);
    check("done",     done,     e_done);
    check("err",      err,      e_err);
  end

  // Write/done monitor used by the literal scenario checks.
  logic [WIDTH-1:0]   mem [ROWS];
  int                 wr_count;
  int                 done_count;
  logic [REGBITS-1:0] first_addr;
  logic [WIDTH-1:0]   first_data;
  bit                 saw_ff;
  always @(negedge ph1) begin
    if (reset && wr_en) begin
      if (wr_count == 0) begin
        first_addr = wr_addr;
        first_data = wr_data;
      end
      mem[wr_addr] = wr_data;
      wr_count++;
      if (wr_data == 8'hFF) saw_ff = 1;
    end
    if (reset && done) done_count++;
  end

  // ---------------------------------------------------------------- stimulus
  task automatic step(input bit ls, input bit v, input logic [WIDTH-1:0] d);
    @(negedge ph1);
    #1;
    load_start = ls;
    in_valid   = v;
    in_data    = d;
  endtask

  task automatic settle();
    @(negedge ph1);
    #2;
  endtask

  task automatic clear_mon();
    wr_count = 0; done_count = 0; saw_ff = 0;
    foreach (mem[i]) mem[i] = 'x;
  endtask

  // Full load with optional random gaps; bad_sum corrupts the checksum.
  task automatic load_words(input logic [WIDTH-1:0] rows[ROWS], input bit gaps, input bit bad_sum);
    logic [WIDTH-1:0] x = '0;
    step(1, 0, '0);
    for (int i = 0; i <= ROWS; i++) begin
      while (gaps && ($urandom_range(0, 2) == 0)) step(0, 0, WIDTH'($urandom));
      if (i < ROWS) begin
        step(0, 1, rows[i]);
        x ^= rows[i];
      end else begin
        step(0, 1, bad_sum ? (x ^ WIDTH'($urandom_range(1, (1 << WIDTH) - 1))) : x);
      end
    end
    step(0, 0, '0);
  endtask

  logic [WIDTH-1:0] nominal [ROWS] = '{8'h18, 8'h24, 8'h42, 8'h81, 8'h81, 8'h42, 8'h24, 8'h18};
  logic [WIDTH-1:0] glider  [ROWS] = '{8'h40, 8'h20, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [WIDTH-1:0] rnd     [ROWS];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; load_start = 0; in_valid = 0; in_data = '0;
    clear_mon();
    repeat (2) @(negedge ph1);
    #1;
    check("reset_run_en", run_en, 0);
    check("reset_busy",   busy,   0);
    check("reset_wr_en",  wr_en,  0);
    reset = 1;
    step(0, 1, 8'h33);  // idle: word must be ignored

    // Nominal load, checksum 0x00.
    clear_mon();
    step(1, 0, '0);
    foreach (nominal[i]) step(0, 1, nominal[i]);
    step(0, 1, 8'h00);
    step(0, 0, '0);
    settle();
    check("nom_writes", wr_count, 8);
    foreach (nominal[i]) check("nom_row", mem[i], nominal[i]);
    check("nom_done",   done_count, 1);
    check("nom_run_en", run_en, 1);
    check("nom_err",    err, 0);

    // Bad checksum 0x01.
    clear_mon();
    step(1, 0, '0);
    foreach (nominal[i]) step(0, 1, nominal[i]);
    step(0, 1, 8'h01);
    step(0, 0, '0);
    settle();
    check("bad_err",    err, 1);
    check("bad_run_en", run_en, 0);
    check("bad_done",   done_count, 0);
    step(1, 0, '0);
    settle();
    check("restart_err",  err, 0);
    check("restart_busy", busy, 1);

    // Glider with 50% valid duty; checksum 0x80.
    clear_mon();
    step(1, 0, '0);
    foreach (glider[i]) begin
      step(0, 1, glider[i]);
      step(0, 0, WIDTH'($urandom));
    end
    step(0, 1, 8'h80);
    step(0, 0, '0);
    settle();
    check("gl_writes", wr_count, 8);
    foreach (glider[i]) check("gl_row", mem[i], glider[i]);
    check("gl_run_en", run_en, 1);

    // Abort after 3 rows with 0xFF offered alongside load_start.
    step(1, 0, '0);
    step(0, 1, 8'h11);
    step(0, 1, 8'h22);
    step(0, 1, 8'h33);
    step(0, 0, '0);
    clear_mon();
    step(1, 1, 8'hFF);
    step(0, 1, 8'h5A);
    step(0, 0, '0);
    settle();
    check("abort_first_addr", first_addr, 0);
    check("abort_first_data", first_data, 8'h5A);
    check("abort_no_ff",      saw_ff, 0);
    for (int i = 1; i <= ROWS; i++) step(0, 1, (i < ROWS) ? 8'h00 : 8'h5A);
    step(0, 0, '0);
    settle();
    check("abort_run_en", run_en, 1);

    // Reload from RUN.
    step(1, 0, '0);
    settle();
    check("reload_run_en", run_en, 0);
    check("reload_busy",   busy, 1);
    foreach (rnd[i]) rnd[i] = WIDTH'($urandom);
    load_words(rnd, 0, 0);
    settle();
    check("reload_done_run", run_en, 1);

    // Async reset between edges mid-load.
    step(1, 0, '0);
    step(0, 1, 8'hA1);
    step(0, 1, 8'hA2);
    step(0, 1, 8'hA3);
    @(negedge ph1);
    #3;
    reset = 0;
    #1;
    check("areset_busy",     busy, 0);
    check("areset_in_ready", in_ready, 0);
    check("areset_wr_en",    wr_en, 0);
    check("areset_wr_data",  wr_data, 0);
    @(negedge ph1);
    #3;
    reset = 1;
    step(0, 0, '0);
    settle();
    check("areset_idle_busy", busy, 0);
    check("areset_idle_run",  run_en, 0);

    // Random loads: gaps, bad checksums and occasional mid-load restarts.
    for (int n = 0; n < 40; n++) begin
      foreach (rnd[i]) rnd[i] = WIDTH'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        step(1, 0, '0);
        repeat ($urandom_range(1, ROWS)) step(0, $urandom_range(0, 1), WIDTH'($urandom));
        if ($urandom_range(0, 1) == 1) step(1, 1, WIDTH'($urandom));
      end
      load_words(rnd, 1, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) step(0, $urandom_range(0, 1), WIDTH'($urandom));
    end

    step(0, 0, '0);
    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seed_loader.md
# seed_loader

Loads an initial Game-of-Life generation into the current-state register file before the generation controller is allowed to run. Accepts one row word per valid/ready handshake, writes it to the row store, then checks a trailing XOR checksum word. On a match it releases the controller via `run_en`; on a mismatch it holds the array frozen and flags an error. It sits directly upstream of the generation controller and the current-state row store, sharing their write port.

## Interface
- `WIDTH`, default 8: cells per row, which is also the row word width.
- `REGBITS`, default 3: row-address width; ROWS = 2**REGBITS.
- `ph1`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low; asserting it (0) forces the reset state immediately.
- `load_start`, input, 1: single-cycle request to begin or restart a load.
- `in_valid`, input, 1: `in_data` holds a valid word.
- `in_data`, input, WIDTH: a row word, or the checksum word.
- `in_ready`, output, 1: loader accepts a word this cycle.
- `wr_en`, output, 1: write strobe to the row store.
- `wr_addr`, output, REGBITS: row address to write.
- `wr_data`, output, WIDTH: row value to write.
- `run_en`, output, 1: enables the generation controller.
- `busy`, output, 1: a load is in progress.
- `done`, output, 1: one-cycle pulse when a load is verified.
- `err`, output, 1: checksum mismatch; sticky.

## Operation
- States: IDLE, LOAD, CHECK, RUN, ERR. Reset enters IDLE.
- Internal registers:
  - `cnt`: REGBITS-bit row counter.
  - `acc`: WIDTH-bit XOR accumulator.
- Accept: accept = `in_valid` & `in_ready`.
- `in_ready` is combinational: 1 only when the state is LOAD or CHECK and `load_start` is 0.
- `load_start` from any state:
  - Next state is LOAD; `cnt` and `acc` clear to 0; `err` clears.
  - `load_start` takes priority over any word presented in the same cycle. That word is not accepted.
- LOAD, on accept:
  - Capture `wr_addr` = `cnt` and `wr_data` = `in_data`.
  - Update `acc` ^= `in_data`.
  - If `cnt` == ROWS-1, move to CHECK; otherwise increment `cnt`.
- CHECK, on accept:
  - No row-store write.
  - If `in_data` == `acc`, move to RUN and pulse `done`.
  - Otherwise move to ERR and set `err`.
- RUN: `run_en` = 1. Stays in RUN until `load_start`.
- ERR: `run_en` = 0 and `err` = 1. Stays in ERR until `load_start`.
- `busy` = 1 exactly when the state is LOAD or CHECK.
- `run_en` = 1 exactly when the state is RUN. It drops in the same cycle the state leaves RUN, so the controller never sees a partially loaded array.
- `cnt` does not wrap within a load: after exactly ROWS row words, the next word is always treated as the checksum.
- A pause on `in_valid` (no accept) holds all state; there is no timeout.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `run_en`=0, `busy`=0, `done`=0, `err`=0, `cnt`=0, `acc`=0.
- `wr_en`, `wr_addr`, `wr_data`, `done` and `err` are registered.
- Write latency: a row accepted at edge n gives `wr_en`=1 with that address and data during the cycle after edge n. `wr_en` is 0 in every other cycle.
- Throughput: back-to-back accepts are allowed, one word per cycle. A minimum full load takes ROWS+1 accepting cycles.
- Checksum accepted at edge m:
  - Match: state is RUN after edge m; `run_en`=1 and `done`=1 in the following cycle; `done` is 0 after edge m+1.
  - Mismatch: `err`=1 from the cycle after edge m.
- `load_start` at edge k: `busy`=1 and `run_en`=0 from the cycle after edge k; `in_ready` is 1 in the next cycle.
- A `wr_en` pulse already registered at the edge that sees `load_start` still completes. The reload overwrites that row later.
- Reset mid-load: outputs return to reset values immediately, with no clock needed. Any partial row-store contents are left as they are; `run_en` stays 0 until a full verified load completes.

## Test plan
- Nominal load (WIDTH=8, ROWS=8): send rows 0x18,0x24,0x42,0x81,0x81,0x42,0x24,0x18, then checksum 0x00. Expect 8 `wr_en` pulses at addresses 0..7 with matching data, one `done` pulse, then `run_en`=1 and `err`=0.
- Bad checksum: same rows, checksum 0x01. Expect state ERR with `err`=1, `run_en`=0, and no `done`. A following `load_start` clears `err`.
- Throttled source: toggle `in_valid` with 50% duty during a glider load (rows 0x40,0x20,0xE0, then 0x00 ×5, checksum 0x80). Writes occur only on accepts, in order, and `run_en` rises after the checksum.
- Abort: `load_start` after 3 rows, together with a valid word 0xFF. Expect 0xFF not accepted, `cnt` restarted, and the next row written to address 0.
- Reload from RUN: `load_start` while `run_en`=1. Expect `run_en`=0 and `busy`=1 the next cycle; the new load completes normally.
- Async reset: drive `reset`=0 mid-load between clock edges. Expect all outputs 0 immediately and the state IDLE after release.
